// File: rtl/ami_rx_unit.sv
// ami_rx_unit: receiving end of the 256-bit MCSE AMI output channel.
// Captures each message with a four-phase handshake (ami_in nonzero -> ack,
// ami_in back to zero -> ack released). Captured messages go into a message
// FIFO. The host reads each message as eight 32-bit words under valid/ready.
// Optional feature macro: AMI_SEQ_CHK_EN enables sequence-number checking,
// which drives seq_err. Without the macro, seq_err is tied low.
module ami_rx_unit #(
   parameter int  DEPTH = 4,
   localparam int LVL_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [255:0]     ami_in,
   output logic             ami_ack,
   output logic [31:0]      host_rdata,
   output logic             host_rvalid,
   input  logic             host_rready,
   output logic [LVL_W-1:0] fifo_level,
   output logic             seq_err,
   input  logic             clr_err
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [255:0]       mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]   level_q;
   logic [2:0]         word_idx_q;
   logic [2:0]         word_sel;
   logic [255:0]       head_msg;
   logic               msg_valid;
   logic               fifo_full;
   logic               push;
   logic               host_fire;
   logic               pop;

   assign msg_valid = (ami_in[255:248] != 8'h00);
   assign fifo_full = (level_q == LVL_W'(DEPTH));
   assign host_fire = host_rvalid && host_rready;
   assign pop       = host_fire && (word_idx_q == 3'd7);

   // Handshake FSM next state: capture in IDLE, wait for an all-zero channel in ACK.
   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      case (state_q)
         IDLE: begin
            // A full FIFO holds the sender off by withholding the ack; nothing is dropped.
            if (msg_valid && !fifo_full) begin
               push    = 1'b1;
               state_d = ACK;
            end
         end
         ACK: begin
            if (ami_in == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
      else      state_q <= state_d;
   end

   assign ami_ack = (state_q == ACK);

   // Message storage: written on capture, read combinationally at the head.
   // NOTE: the storage array has no reset; an entry is never read before the level counter covers it.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_q] <= ami_in;
   end

   // FIFO pointers, occupancy and the host word index within the head message.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         word_idx_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (host_fire) word_idx_q <= word_idx_q + 3'd1;   // wraps 7 -> 0 on the popping word
         if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // Word 0 is the most significant 32 bits of the message.
   assign head_msg    = mem[rd_ptr_q];
   assign word_sel    = 3'd7 - word_idx_q;
   assign host_rdata  = head_msg[{word_sel, 5'd0} +: 32];
   assign host_rvalid = (level_q != '0);
   assign fifo_level  = level_q;

`ifdef AMI_SEQ_CHK_EN
   logic [7:0] exp_seq_q;
   logic       seq_err_q;
   logic       seq_mismatch;

   assign seq_mismatch = push && (ami_in[247:240] != exp_seq_q);

   // Sequence tracking: expect received+1 after every capture; a mismatch beats a clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_seq_q <= 8'h00;
         seq_err_q <= 1'b0;
      end else begin
         if (push) exp_seq_q <= ami_in[247:240] + 8'd1;
         if (seq_mismatch)  seq_err_q <= 1'b1;
         else if (clr_err)  seq_err_q <= 1'b0;
      end
   end

   assign seq_err = seq_err_q;
`else
   logic unused_clr_err;

   assign unused_clr_err = clr_err;
   assign seq_err        = 1'b0;
`endif

endmodule

// File: tb/tb_ami_rx_unit.sv
// Self-checking bench for ami_rx_unit. The reference model is a message queue
// plus an expected-sequence counter, both updated whenever a capture is observed.
// The bench drives inputs and samples outputs on the falling clock edge.
module tb_ami_rx_unit;

   localparam int DEPTH = 4;
   localparam int LVL_W = $clog2(DEPTH + 1);

   logic             clk;
   logic             rst;
   logic [255:0]     ami_in;
   logic             ami_ack;
   logic [31:0]      host_rdata;
   logic             host_rvalid;
   logic             host_rready;
   logic [LVL_W-1:0] fifo_level;
   logic             seq_err;
   logic             clr_err;

   int checks = 0;
   int passes = 0;

   logic [255:0] model_q[$];
   logic [7:0]   model_exp = 8'h00;
   logic         model_err = 1'b0;

   ami_rx_unit #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .ami_in      (ami_in),
      .ami_ack     (ami_ack),
      .host_rdata  (host_rdata),
      .host_rvalid (host_rvalid),
      .host_rready (host_rready),
      .fifo_level  (fifo_level),
      .seq_err     (seq_err),
      .clr_err     (clr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input logic [255:0] m, input int w);
      return m[255 - 32*w -: 32];
   endfunction

   function automatic logic [255:0] rand_msg(input logic [7:0] seq);
      logic [255:0] m;
      for (int k = 0; k < 8; k++) m[k*32 +: 32] = $urandom;
      m[255:248] = 8'($urandom_range(1, 255));
      m[247:240] = seq;
      return m;
   endfunction

   task automatic model_capture(input logic [255:0] m);
      model_q.push_back(m);
`ifdef AMI_SEQ_CHK_EN
      if (m[247:240] != model_exp) model_err = 1'b1;
      model_exp = m[247:240] + 8'd1;
`endif
   endtask

   task automatic do_reset();
      rst         = 1'b0;
      ami_in      = '0;
      host_rready = 1'b0;
      clr_err     = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      model_q.delete();
      model_exp = 8'h00;
      model_err = 1'b0;
   endtask

   // Present a message, wait (bounded) for the ack, then complete the handshake.
   task automatic send(input logic [255:0] m, output int lat);
      lat    = 0;
      ami_in = m;
      do begin
         @(negedge clk);
         lat++;
      end while (ami_ack !== 1'b1 && lat < 200);
      checks++;
      if (ami_ack !== 1'b1) $display("FAIL send_ack: ami_ack=%b required 1 after %0d cycles", ami_ack, lat);
      else begin passes++; model_capture(m); end
      ami_in = '0;
      @(negedge clk);
      checks++;
      if (ami_ack !== 1'b0) $display("FAIL send_ack_release: ami_ack=%b required 0", ami_ack);
      else passes++;
   endtask

   // Read the head message word by word, optionally with random host stalls.
   task automatic read_head(input bit stall);
      logic [255:0] exp_m;
      int w, n;
      logic rr;
      checks++;
      if (model_q.size() == 0) begin
         $display("FAIL read_head_model: model empty, required a queued message");
         return;
      end
      passes++;
      exp_m = model_q[0];
      w = 0;
      n = 0;
      while (w < 8 && n < 100) begin
         rr = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         host_rready = rr;
         checks++;
         if (host_rvalid !== 1'b1 || host_rdata !== word_of(exp_m, w))
            $display("FAIL read_word%0d: rvalid=%b data=%h required rvalid=1 data=%h",
                     w, host_rvalid, host_rdata, word_of(exp_m, w));
         else passes++;
         @(negedge clk);
         if (rr) w++;
         n++;
      end
      host_rready = 1'b0;
      void'(model_q.pop_front());
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (ami_ack !== 1'b0 || host_rvalid !== 1'b0 || fifo_level !== '0 || seq_err !== 1'b0)
            $display("FAIL reset_state: ack=%b rvalid=%b level=%0d seq_err=%b required 0/0/0/0",
                     ami_ack, host_rvalid, fifo_level, seq_err);
         else passes++;
         @(negedge clk);
      end
   endtask

   task automatic test_single();
      logic [255:0] m;
      // Host ready while empty must not move the word index.
      host_rready = 1'b1;
      repeat (3) @(negedge clk);
      host_rready = 1'b0;
      m = {8'h01, 8'h00, {30{8'hA5}}};
      ami_in = m;
      @(negedge clk);
      checks++;
      if (ami_ack !== 1'b1 || host_rvalid !== 1'b1 || fifo_level !== LVL_W'(1))
         $display("FAIL single_capture: ack=%b rvalid=%b level=%0d required 1/1/1",
                  ami_ack, host_rvalid, fifo_level);
      else passes++;
      model_capture(m);
      checks++;
      if (host_rdata !== 32'h0100A5A5)
         $display("FAIL single_word0: data=%h required 0100a5a5", host_rdata);
      else passes++;
      ami_in = '0;
      #1;
      checks++;
      if (ami_ack !== 1'b1) $display("FAIL single_ack_hold: ami_ack=%b required 1", ami_ack);
      else passes++;
      @(negedge clk);
      checks++;
      if (ami_ack !== 1'b0) $display("FAIL single_ack_fall: ami_ack=%b required 0", ami_ack);
      else passes++;
      read_head(1'b0);
      checks++;
      if (fifo_level !== '0 || host_rvalid !== 1'b0)
         $display("FAIL single_drain: level=%0d rvalid=%b required 0/0", fifo_level, host_rvalid);
      else passes++;
   endtask

   task automatic test_backpressure();
      logic [255:0] m;
      int lat, n;
      host_rready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         send(rand_msg(model_exp), lat);
      end
      m = rand_msg(model_exp);
      ami_in = m;
      repeat (4) @(negedge clk);
      checks++;
      if (ami_ack !== 1'b0 || fifo_level !== LVL_W'(DEPTH))
         $display("FAIL bp_hold: ack=%b level=%0d required 0/%0d", ami_ack, fifo_level, DEPTH);
      else passes++;
      read_head(1'b0);
      n = 0;
      while (ami_ack !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (ami_ack !== 1'b1 || fifo_level !== LVL_W'(DEPTH))
         $display("FAIL bp_release: ack=%b level=%0d required 1/%0d", ami_ack, fifo_level, DEPTH);
      else begin passes++; model_capture(m); end
      ami_in = '0;
      @(negedge clk);
      while (model_q.size() > 0) read_head(1'b1);
      checks++;
      if (fifo_level !== '0) $display("FAIL bp_drain: level=%0d required 0", fifo_level);
      else passes++;
   endtask

   task automatic test_simul();
      logic [255:0] a, b;
      int lat;
      a = rand_msg(model_exp);
      send(a, lat);
      host_rready = 1'b1;
      for (int w = 0; w < 7; w++) begin
         checks++;
         if (host_rdata !== word_of(a, w))
            $display("FAIL simul_word%0d: data=%h required %h", w, host_rdata, word_of(a, w));
         else passes++;
         @(negedge clk);
      end
      checks++;
      if (host_rdata !== word_of(a, 7))
         $display("FAIL simul_word7: data=%h required %h", host_rdata, word_of(a, 7));
      else passes++;
      b = rand_msg(model_exp + 8'd1);
      ami_in = b;
      @(negedge clk);
      host_rready = 1'b0;
      void'(model_q.pop_front());
      model_capture(b);
      checks++;
      if (fifo_level !== LVL_W'(1) || ami_ack !== 1'b1 || host_rdata !== word_of(b, 0))
         $display("FAIL simul_push_pop: level=%0d ack=%b data=%h required 1/1/%h",
                  fifo_level, ami_ack, host_rdata, word_of(b, 0));
      else passes++;
      ami_in = '0;
      @(negedge clk);
      read_head(1'b0);
   endtask

   task automatic test_seq();
      int lat;
      logic [7:0] seqs [4];
      seqs = '{8'd0, 8'd1, 8'd3, 8'd4};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         send(rand_msg(seqs[i]), lat);
         checks++;
         if (seq_err !== model_err)
            $display("FAIL seq_after_%0d: seq_err=%b required %b", seqs[i], seq_err, model_err);
         else passes++;
         read_head(1'b0);
         if (i == 2) begin
            clr_err = 1'b1;
            @(negedge clk);
            clr_err   = 1'b0;
            model_err = 1'b0;
            checks++;
            if (seq_err !== 1'b0) $display("FAIL seq_clear: seq_err=%b required 0", seq_err);
            else passes++;
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] s;
      int lat;
      for (int it = 0; it < 60; it++) begin
         if ($urandom_range(0, 1) == 1 && model_q.size() < DEPTH) begin
            s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : model_exp;
            send(rand_msg(s), lat);
         end else if (model_q.size() > 0) begin
            read_head(1'b1);
         end else begin
            @(negedge clk);
         end
         checks++;
         if (fifo_level !== LVL_W'(model_q.size()) || seq_err !== model_err)
            $display("FAIL random_state%0d: level=%0d seq_err=%b required %0d/%b",
                     it, fifo_level, seq_err, model_q.size(), model_err);
         else passes++;
      end
      while (model_q.size() > 0) read_head(1'b1);
   endtask

   task automatic test_reset_mid();
      int lat;
      int n;
      send(rand_msg(model_exp), lat);
      ami_in = rand_msg(model_exp);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (ami_ack !== 1'b1 && n < 20);
      checks++;
      if (ami_ack !== 1'b1 || fifo_level !== LVL_W'(2))
         $display("FAIL rstmid_setup: ack=%b level=%0d required 1/2", ami_ack, fifo_level);
      else passes++;
      #2 rst = 1'b0;
      #1;
      checks++;
      if (ami_ack !== 1'b0 || host_rvalid !== 1'b0 || fifo_level !== '0)
         $display("FAIL rstmid_async: ack=%b rvalid=%b level=%0d required 0/0/0",
                  ami_ack, host_rvalid, fifo_level);
      else passes++;
      ami_in = '0;
      @(negedge clk);
      rst = 1'b1;
      model_q.delete();
      model_exp = 8'h00;
      model_err = 1'b0;
      @(negedge clk);
      checks++;
      if (ami_ack !== 1'b0 || fifo_level !== '0)
         $display("FAIL rstmid_after: ack=%b level=%0d required 0/0", ami_ack, fifo_level);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_simul();
      test_seq();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
